// File: rtl/if_id_buffer_pkg.sv
// Shared pipeline parameters for the fetch/decode boundary: the NOP
// encoding used when nothing valid is queued, and the field widths of one
// queued instruction/PC pair.
package if_id_buffer_pkg;

  localparam int INS_W   = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = INS_W + PC_W;

  // addi x0,x0,0 -- also used by decode and flush logic as the bubble word
  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  pc;
  } entry_t;

endpackage

// File: rtl/if_id_buffer_ins_fifo_mem.sv
// Storage for the instruction buffer: DEPTH entries of W bits, one
// synchronous write port and one asynchronous read port so the head entry
// is visible in the same cycle the read pointer points at it.
module ins_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_reg [DEPTH];

  // Write the addressed entry; contents are never cleared, the control
  // logic decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/if_id_buffer.sv
// Instruction buffer between fetch and decode. Queues up to DEPTH
// instruction/PC pairs and always presents the oldest one; presents NOP
// (with PC 0) when empty. Flush discards everything in one cycle.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int               DEPTH = 2,
  parameter logic [INS_W-1:0] NOP   = NOP_INS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  input  logic [INS_W-1:0]         INS_IN,
  input  logic [PC_W-1:0]          PC_IN,
  input  logic                     INS_CACHE_READY,
  input  logic                     STALL_ENABLE,
  input  logic                     FLUSH,
  output logic                     FETCH_READY,
  output logic [INS_W-1:0]         INSTRUCTION,
  output logic [PC_W-1:0]          PC_OUT,
  output logic                     OUT_VALID,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rp_reg, rp_next;
  logic [AW-1:0] wp_reg, wp_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push, pop;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  entry_t        head_entry;

  // Flags come from the registered count only, so FETCH_READY has no
  // path from STALL_ENABLE; a full buffer refuses a push even if decode
  // pops in the same cycle.
  assign FETCH_READY = (count_reg != CW'(DEPTH));
  assign OUT_VALID   = (count_reg != '0);
  assign COUNT       = count_reg;

  assign push = IN_VALID & INS_CACHE_READY & FETCH_READY & ~FLUSH;
  assign pop  = OUT_VALID & STALL_ENABLE & ~FLUSH;

  assign wr_data = {INS_IN, PC_IN};

  ins_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wp_reg),
    .wr_data (wr_data),
    .rd_addr (rp_reg),
    .rd_data (rd_data)
  );

  assign head_entry  = entry_t'(rd_data);
  assign INSTRUCTION = OUT_VALID ? head_entry.ins : NOP;
  assign PC_OUT      = OUT_VALID ? head_entry.pc  : '0;

  // Next-state for pointers and occupancy; pointers wrap naturally.
  always_comb begin
    rp_next    = rp_reg;
    wp_next    = wp_reg;
    count_next = count_reg;
    if (push) begin
      wp_next = wp_reg + AW'(1);
    end
    if (pop) begin
      rp_next = rp_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Reset and flush both empty the buffer; reset wins trivially since the
  // result is the same.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      rp_reg    <= '0;
      wp_reg    <= '0;
      count_reg <= '0;
    end else begin
      rp_reg    <= rp_next;
      wp_reg    <= wp_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with DEPTH = 2.
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] ins_in;
  logic [31:0] pc_in;
  logic        cache_ready;
  logic        stall_enable;
  logic        flush;
  logic        fetch_ready;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        out_valid;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  if_id_buffer #(.DEPTH(2), .NOP(32'h0000_0013)) dut (
    .CLK             (clk),
    .RST             (rst),
    .IN_VALID        (in_valid),
    .INS_IN          (ins_in),
    .PC_IN           (pc_in),
    .INS_CACHE_READY (cache_ready),
    .STALL_ENABLE    (stall_enable),
    .FLUSH           (flush),
    .FETCH_READY     (fetch_ready),
    .INSTRUCTION     (instruction),
    .PC_OUT          (pc_out),
    .OUT_VALID       (out_valid),
    .COUNT           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic stall_en);
    in_valid     = v;
    ins_in       = ins;
    pc_in        = pc;
    stall_enable = stall_en;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                             input logic [1:0] cnt);
    check({tag, ".ins"}, 64'(instruction), 64'(ins));
    check({tag, ".pc"},  64'(pc_out),      64'(pc));
    check({tag, ".cnt"}, 64'(count),       64'(cnt));
  endtask

  logic [31:0] exp_q[$];
  int          n_push;
  int          n_pop;
  int          cyc;
  logic        m_push;
  logic        m_pop;

  initial begin
    rst = 1'b1; flush = 1'b0; cache_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    // Reset / idle
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.fetch_ready", 64'(fetch_ready), 64'd1);
    expect_head("rst", 32'h13, 32'h0, 2'd0);

    // Streaming: each instruction visible one cycle after push, count <= 1
    drive(1'b1, 32'h00A0_0093, 32'h100, 1'b1);
    tick();
    expect_head("stream0", 32'h00A0_0093, 32'h100, 2'd1);
    drive(1'b1, 32'h00B0_0113, 32'h104, 1'b1);
    tick();
    expect_head("stream1", 32'h00B0_0113, 32'h104, 2'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_head("stream_drain", 32'h13, 32'h0, 2'd0);

    // IN_VALID without cache ready: no push
    cache_ready = 1'b0;
    drive(1'b1, 32'hCAFE_0001, 32'h180, 1'b0);
    tick();
    expect_head("no_cache_rdy", 32'h13, 32'h0, 2'd0);
    cache_ready = 1'b1;

    // Stall fill: three pushes, third rejected
    drive(1'b1, 32'h0000_0111, 32'h300, 1'b0);
    tick();
    check("fill1.fetch_ready", 64'(fetch_ready), 64'd1);
    drive(1'b1, 32'h0000_0222, 32'h304, 1'b0);
    tick();
    check("fill2.fetch_ready", 64'(fetch_ready), 64'd0);
    expect_head("fill2", 32'h111, 32'h300, 2'd2);
    drive(1'b1, 32'h0000_0333, 32'h308, 1'b0);
    tick();
    expect_head("fill3_rejected", 32'h111, 32'h300, 2'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_head("release1", 32'h222, 32'h304, 2'd1);
    tick();
    expect_head("release2", 32'h13, 32'h0, 2'd0);

    // Full with simultaneous pop and push: pop happens, push ignored
    drive(1'b1, 32'h0000_0444, 32'h310, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0555, 32'h314, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0666, 32'h318, 1'b1);
    tick();
    expect_head("full_pushpop", 32'h555, 32'h314, 2'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_head("full_drain", 32'h13, 32'h0, 2'd0);

    // Flush with a concurrent push of DEADBEEF
    drive(1'b1, 32'h0000_0777, 32'h320, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0888, 32'h324, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h3F0, 1'b1);
    tick();
    flush = 1'b0;
    expect_head("flush", 32'h13, 32'h0, 2'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h0000_0999, 32'h328, 1'b0);
    tick();
    expect_head("post_flush", 32'h999, 32'h328, 2'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_head("post_flush_drain", 32'h13, 32'h0, 2'd0);

    // Wrap-around: 10 instructions, alternating stalls, order preserved
    exp_q.delete();
    n_push = 0; n_pop = 0; cyc = 0;
    while (n_pop < 10 && cyc < 60) begin
      drive(n_push < 10, 32'h1000 + 32'(n_push), 32'h200 + 32'(4 * n_push), cyc[0]);
      m_push = (n_push < 10) && (exp_q.size() < 2);
      m_pop  = (exp_q.size() > 0) && cyc[0];
      if (m_pop) begin
        check($sformatf("wrap.pop%0d.pc", n_pop), 64'(pc_out), 64'(32'h200 + 32'(4 * n_pop)));
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (m_push) begin
        exp_q.push_back(32'h200 + 32'(4 * n_push));
        n_push++;
      end
      tick();
      cyc++;
      check($sformatf("wrap.c%0d.cnt", cyc), 64'(count), 64'(exp_q.size()));
    end
    check("wrap.completed", 64'(n_pop), 64'd10);
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // RST together with FLUSH behaves as reset
    drive(1'b1, 32'h0000_0AAA, 32'h400, 1'b0);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    expect_head("rst_flush", 32'h13, 32'h0, 2'd0);
    check("rst_flush.fetch_ready", 64'(fetch_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Instruction buffer between the fetch stage and the decode unit. It queues up to `DEPTH` fetched instruction/PC pairs and always presents the oldest one to decode. It absorbs decode stalls (`STALL_ENABLE` low) without stalling the instruction cache that same cycle. On a branch/jump flush it discards all queued instructions and presents a NOP.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; power of two, ≥ 2.
- `NOP`, 32'h0000_0013: instruction presented when the buffer is empty (`addi x0,x0,0`).

Ports (one clock; reset is synchronous and active-high):
- `CLK` input 1: system clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `IN_VALID` input 1: fetch presents a valid instruction this cycle.
- `INS_IN` input 32: fetched instruction word.
- `PC_IN` input 32: PC of `INS_IN`.
- `INS_CACHE_READY` input 1: instruction cache has returned data; a push is qualified by this.
- `STALL_ENABLE` input 1: from decode; 1 = decode consumes the head this cycle, 0 = hold.
- `FLUSH` input 1: redirect from execute; discard all contents.
- `FETCH_READY` output 1: buffer not full. Registered-state derived, with no combinational path from `STALL_ENABLE`.
- `INSTRUCTION` output 32: head instruction, or `NOP` when empty. Feeds the decode unit's `INSTRUCTION` input.
- `PC_OUT` output 32: head PC, or 0 when empty.
- `OUT_VALID` output 1: head entry is valid.
- `COUNT` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: circular array of `DEPTH` {ins, pc} entries.
  - Read pointer `rp` and write pointer `wp` are each $clog2(DEPTH) bits and wrap naturally.
  - `count` is $clog2(DEPTH)+1 bits.
- Push condition: `push = IN_VALID & INS_CACHE_READY & FETCH_READY & !FLUSH`. On push, write entry[wp] and increment `wp`.
- Pop condition: `pop = OUT_VALID & STALL_ENABLE & !FLUSH`. On pop, increment `rp`.
- Count update:
  - push & pop: count unchanged.
  - push only: +1.
  - pop only: −1.
- Output flags:
  - `FETCH_READY = (count != DEPTH)`.
  - `OUT_VALID = (count != 0)`.
- Head outputs:
  - `INSTRUCTION = OUT_VALID ? entry[rp].ins : NOP`.
  - `PC_OUT = OUT_VALID ? entry[rp].pc : 0`.
- Full: when `count == DEPTH`, `FETCH_READY = 0`. A push attempted while full is ignored and no entry is overwritten, even if a pop occurs in the same cycle.
- Empty: pop is impossible. `STALL_ENABLE` high with the buffer empty has no effect.
- Flush: `FLUSH` high sets `rp = wp = 0` and `count = 0`. Any push or pop in the same cycle is dropped. Entry contents need not be cleared.
- `FLUSH` and `RST` together: behaviour is identical to `RST`.
- `IN_VALID` high with `INS_CACHE_READY` low: no push.

## Timing
- Reset values (cycle after `RST` sampled high):
  - `count = 0`, `rp = wp = 0`.
  - `OUT_VALID = 0`, `FETCH_READY = 1`.
  - `INSTRUCTION = NOP`, `PC_OUT = 0`, `COUNT = 0`.
- Reset mid-operation discards all entries exactly as a flush does.
- Latency: an instruction pushed at edge N appears on `INSTRUCTION` after edge N, if the buffer was empty. There is no combinational bypass from `INS_IN` to `INSTRUCTION`.
- Throughput: one push and one pop per cycle. Steady state with `STALL_ENABLE = 1` holds `count` at 1.
- Head outputs are combinational from registered state only. `FETCH_READY` depends on `count` only.
- After a flush at edge N, the first post-flush instruction may be pushed at edge N+1 and is visible after N+1.
- Wrap-around: pointers wrap modulo `DEPTH`. Ordering is preserved across the wrap.

## Structure
- The shared pipeline parameter header holds:
  - the `NOP` encoding (32'h0000_0013), shared with decode and flush logic;
  - the pipeline entry field widths (32-bit ins, 32-bit pc).
- One sub-module, `ins_fifo_mem`: a `DEPTH`×64 register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flush control stay in `if_id_buffer`.

## Test plan
- Reset, then idle: hold `RST` for 2 cycles and release. Required: `OUT_VALID = 0`, `INSTRUCTION = 32'h13`, `FETCH_READY = 1`, `COUNT = 0`.
- Streaming: push 0x00A00093 (PC 0x100) and 0x00B00113 (PC 0x104) on consecutive cycles with `STALL_ENABLE = 1`. Required: decode sees each one cycle after its push, in order, and `COUNT` never exceeds 1.
- Stall fill: `STALL_ENABLE = 0`, push 3 instructions with `DEPTH = 2`. Required: the first two are accepted, `FETCH_READY = 0` after the second, and the third is not written. After release, the head is the first instruction and pops occur in order.
- Simultaneous push/pop at full: `count = 2`, pop and push attempted in the same cycle. Required: the pop occurs, the push is ignored, `COUNT = 1`.
- Flush: `count = 2`, `FLUSH = 1` together with a push of 0xDEADBEEF. Required: next cycle `COUNT = 0`, `INSTRUCTION = 32'h13`, and 0xDEADBEEF is never presented.
- Wrap-around: 10 push/pop cycles with alternating stalls. Required: the output PC sequence exactly matches the input sequence 0x200, 0x204, … 0x224.
